// File: rtl/vga_axi_pkg.sv
// Shared types and burst-geometry helpers for the VGA framebuffer fetch path.
package vga_axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StReq,
    StWaitData,
    StDrain
  } fetch_state_e;

  localparam int unsigned DEF_BURST_LEN  = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  localparam int unsigned BURST_BYTES     = DEF_BURST_LEN * DEF_DATA_WIDTH / 8;
  localparam int unsigned ADDR_ALIGN_BITS = $clog2(BURST_BYTES);

  function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                              input int unsigned data_width);
    return burst_len * (data_width / 8);
  endfunction

  function automatic int unsigned addr_align_bits(input int unsigned burst_len,
                                                  input int unsigned data_width);
    return $clog2(burst_bytes(burst_len, data_width));
  endfunction

endpackage

// File: rtl/vga_fetch_scheduler.sv
// Paces framebuffer burst requests against pixel-FIFO space and frame-start events,
// keeping at most one burst outstanding.
module vga_fetch_scheduler
  import vga_axi_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH             = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH             = 32,
  parameter int unsigned C_M_AXI_BURST_LEN              = 32,
  parameter int unsigned C_M_AXI_NUMBER_OF_BURST        = 25,
  parameter int unsigned C_BITS_WIDTH_FOR_NUMB_OF_BURST = 5,
  parameter int unsigned FIFO_CNT_WIDTH                 = 10
) (
  input  logic                                      M_AXI_ACLK,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]             fb_base_addr,
  input  logic                                      frame_start,
  input  logic [FIFO_CNT_WIDTH-1:0]                 fifo_free,
  output logic                                      burst_req,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             burst_addr,
  input  logic                                      burst_ack,
  input  logic                                      burst_done,
  input  logic                                      burst_err,
  input  logic                                      err_clear,
  output logic [C_BITS_WIDTH_FOR_NUMB_OF_BURST-1:0] burst_idx,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      late_frame,
  output logic                                      rd_error
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned IW = C_BITS_WIDTH_FOR_NUMB_OF_BURST;
  localparam int unsigned ALIGN_BITS = addr_align_bits(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
  localparam logic [AW-1:0] ALIGN_MASK = (AW'(1) << ALIGN_BITS) - AW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(C_M_AXI_NUMBER_OF_BURST - 1);

  fetch_state_e  r_state, w_state_d;
  logic [AW-1:0] r_base, w_base_d;
  logic [AW-1:0] r_pend_base, w_pend_base_d;
  logic          r_pend_start, w_pend_start_d;
  logic [IW-1:0] r_burst_idx, w_burst_idx_d;
  logic          r_burst_req, w_burst_req_d;
  logic [AW-1:0] r_burst_addr, w_burst_addr_d;
  logic          r_frame_done, w_frame_done_d;
  logic          r_late_frame, w_late_frame_d;
  logic          r_rd_error, w_rd_error_d;

  logic          w_set_late;
  logic          w_set_err;
  logic [AW-1:0] w_fb_aligned;
  logic [AW-1:0] w_next_addr;
  logic          w_space_ok;
  logic          w_last;

  assign w_fb_aligned = fb_base_addr & ~ALIGN_MASK;
  // Burst size is a power of two, so the offset is the index shifted into place.
  assign w_next_addr  = r_base + (AW'(r_burst_idx) << ALIGN_BITS);
  assign w_space_ok   = 32'(fifo_free) >= 32'(C_M_AXI_BURST_LEN);
  assign w_last       = (r_burst_idx == LAST_IDX);

  always_comb begin
    w_state_d      = r_state;
    w_base_d       = r_base;
    w_pend_base_d  = r_pend_base;
    w_pend_start_d = r_pend_start;
    w_burst_idx_d  = r_burst_idx;
    w_burst_req_d  = r_burst_req;
    w_burst_addr_d = r_burst_addr;
    w_frame_done_d = 1'b0;
    w_set_late     = 1'b0;
    w_set_err      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (frame_start && enable) begin
          w_base_d      = w_fb_aligned;
          w_burst_idx_d = '0;
          w_state_d     = StWaitSpace;
        end
      end
      StWaitSpace: begin
        if (!enable) begin
          w_state_d = StIdle;
        end else if (frame_start) begin
          w_set_late    = 1'b1;
          w_base_d      = w_fb_aligned;
          w_burst_idx_d = '0;
        end else if (w_space_ok) begin
          w_burst_req_d  = 1'b1;
          w_burst_addr_d = w_next_addr;
          w_state_d      = StReq;
        end
      end
      StReq: begin
        if (frame_start) begin
          w_set_late     = 1'b1;
          w_pend_start_d = 1'b1;
          w_pend_base_d  = w_fb_aligned;
        end
        if (burst_ack) begin
          w_burst_req_d = 1'b0;
          w_state_d     = StWaitData;
        end
      end
      StWaitData: begin
        if (burst_done) begin
          w_set_err = burst_err;
          // A start coinciding with the final done is on time; any other one restarts late.
          if (frame_start && (r_pend_start || !w_last)) begin
            w_set_late     = 1'b1;
            w_base_d       = w_fb_aligned;
            w_burst_idx_d  = '0;
            w_pend_start_d = 1'b0;
            w_state_d      = StWaitSpace;
          end else if (r_pend_start) begin
            w_base_d       = r_pend_base;
            w_burst_idx_d  = '0;
            w_pend_start_d = 1'b0;
            w_state_d      = StWaitSpace;
          end else if (w_last) begin
            w_frame_done_d = 1'b1;
            w_burst_idx_d  = '0;
            if (frame_start && enable) begin
              w_base_d  = w_fb_aligned;
              w_state_d = StWaitSpace;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_burst_idx_d = r_burst_idx + IW'(1);
            w_state_d     = enable ? StWaitSpace : StIdle;
          end
        end else begin
          if (frame_start) begin
            w_set_late     = 1'b1;
            w_pend_start_d = 1'b1;
            w_pend_base_d  = w_fb_aligned;
          end
          if (!enable) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (burst_done) begin
          w_set_err      = burst_err;
          w_pend_start_d = 1'b0;
          w_state_d      = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Set events take priority over a simultaneous clear.
    w_late_frame_d = (r_late_frame & ~err_clear) | w_set_late;
    w_rd_error_d   = (r_rd_error & ~err_clear) | w_set_err;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (reset) begin
      r_state      <= StIdle;
      r_base       <= '0;
      r_pend_base  <= '0;
      r_pend_start <= 1'b0;
      r_burst_idx  <= '0;
      r_burst_req  <= 1'b0;
      r_burst_addr <= '0;
      r_frame_done <= 1'b0;
      r_late_frame <= 1'b0;
      r_rd_error   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_base       <= w_base_d;
      r_pend_base  <= w_pend_base_d;
      r_pend_start <= w_pend_start_d;
      r_burst_idx  <= w_burst_idx_d;
      r_burst_req  <= w_burst_req_d;
      r_burst_addr <= w_burst_addr_d;
      r_frame_done <= w_frame_done_d;
      r_late_frame <= w_late_frame_d;
      r_rd_error   <= w_rd_error_d;
    end
  end

  assign burst_req  = r_burst_req;
  assign burst_addr = r_burst_addr;
  assign burst_idx  = r_burst_idx;
  assign busy       = (r_state != StIdle);
  assign frame_done = r_frame_done;
  assign late_frame = r_late_frame;
  assign rd_error   = r_rd_error;

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Scoreboard bench for vga_fetch_scheduler: stimulus queues expected requests,
// a monitor pops and compares them as the DUT issues bursts.
module tb_vga_fetch_scheduler;

  localparam int AW = 32;
  localparam int IW = 5;
  localparam int FW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          enable;
  logic [AW-1:0] fb_base_addr;
  logic          frame_start;
  logic [FW-1:0] fifo_free;
  logic          burst_req;
  logic [AW-1:0] burst_addr;
  logic          burst_ack;
  logic          burst_done;
  logic          burst_err;
  logic          err_clear;
  logic [IW-1:0] burst_idx;
  logic          busy;
  logic          frame_done;
  logic          late_frame;
  logic          rd_error;

  vga_fetch_scheduler dut (
    .M_AXI_ACLK   (clk),
    .reset        (reset),
    .enable       (enable),
    .fb_base_addr (fb_base_addr),
    .frame_start  (frame_start),
    .fifo_free    (fifo_free),
    .burst_req    (burst_req),
    .burst_addr   (burst_addr),
    .burst_ack    (burst_ack),
    .burst_done   (burst_done),
    .burst_err    (burst_err),
    .err_clear    (err_clear),
    .burst_idx    (burst_idx),
    .busy         (busy),
    .frame_done   (frame_done),
    .late_frame   (late_frame),
    .rd_error     (rd_error)
  );

  typedef struct {
    logic [31:0] addr;
    int          idx;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_fd = 0;
  int   n_req = 0;
  int   ack_delay = 3;
  int   done_delay = 40;
  int   err_idx = -1;
  bit   chk_done_lat = 1'b0;
  int   done_cyc = -1;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base, input int first, input int last);
    for (int n = first; n <= last; n++) begin
      exp_q.push_back('{addr: base + 32'(n) * 32'h80, idx: n});
    end
  endtask

  task automatic pulse_fs(input logic [31:0] base);
    @(posedge clk); #1;
    fb_base_addr = base;
    frame_start  = 1'b1;
    @(posedge clk); #1;
    frame_start  = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  // sel: 0 idle, 1 frame_done, 2 req at idx, 3 req low, 4 done at idx
  task automatic wait_until(input int sel, input int idx, input int max_cyc, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = !busy;
        1:       hit = frame_done;
        2:       hit = burst_req && (int'(burst_idx) == idx);
        3:       hit = !burst_req;
        4:       hit = burst_done && (int'(burst_idx) == idx);
        default: hit = 1'b1;
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout %s: condition not reached within %0d cycles", name, max_cyc);
    end
    #1;
  endtask

  // Read-master model: ack after ack_delay cycles, done after done_delay more.
  initial begin : master
    int ad;
    int dd;
    int idx;
    burst_ack  = 1'b0;
    burst_done = 1'b0;
    burst_err  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (burst_req && !reset) begin
        ad  = ack_delay;
        dd  = done_delay;
        idx = int'(burst_idx);
        repeat (ad - 1) begin @(posedge clk); #1; end
        burst_ack = 1'b1;
        @(posedge clk); #1;
        burst_ack = 1'b0;
        repeat (dd - 1) begin @(posedge clk); #1; end
        burst_done = 1'b1;
        burst_err  = (idx == err_idx);
        @(posedge clk); #1;
        burst_done = 1'b0;
        burst_err  = 1'b0;
      end
    end
  end

  initial begin : monitor
    req_t        e;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_fd = 1'b0;
    logic [31:0] cur_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_fd  = 1'b0;
      end else begin
        cyc++;
        if (burst_done && chk_done_lat) done_cyc = cyc;
        if (prev_req && !prev_ack) check("req_hold_until_ack", 32'(burst_req), 32'd1);
        if (prev_req && prev_ack)  check("req_drop_after_ack", 32'(burst_req), 32'd0);
        if (burst_req && !prev_req) begin
          n_req++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_req: got addr 0x%0h idx %0d, expected no request",
                     burst_addr, burst_idx);
          end else begin
            e = exp_q.pop_front();
            cur_addr = e.addr;
            check("req_addr", burst_addr, e.addr);
            check("req_idx", 32'(burst_idx), 32'(e.idx));
          end
          if (chk_done_lat && done_cyc >= 0) begin
            check("done_to_req_latency", 32'(cyc - done_cyc), 32'd2);
            done_cyc = -1;
          end
        end else if (burst_req) begin
          check("req_addr_stable", burst_addr, cur_addr);
        end
        if (frame_done) begin
          if (prev_fd) check("frame_done_single_cycle", 32'd1, 32'd0);
          n_fd++;
        end
        prev_req = burst_req;
        prev_ack = burst_ack;
        prev_fd  = frame_done;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
             n_checks, n_errors);
    $fatal(1);
  end

  initial begin : stim
    int fd0;
    int nr0;
    reset        = 1'b1;
    enable       = 1'b0;
    frame_start  = 1'b0;
    err_clear    = 1'b0;
    fb_base_addr = '0;
    fifo_free    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_burst_req", 32'(burst_req), 32'd0);
    check("rst_burst_addr", burst_addr, 32'd0);
    check("rst_burst_idx", 32'(burst_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_late_frame", 32'(late_frame), 32'd0);
    check("rst_rd_error", 32'(rd_error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full frame, 25 bursts, ack in 3 and done in 40.
    enable    = 1'b1;
    fifo_free = 10'd1023;
    push_frame(32'h1000_0000, 0, 24);
    chk_done_lat = 1'b1;
    pulse_fs(32'h1000_0000);
    @(negedge clk);
    check("t1_fs_to_req_cycle1", 32'(burst_req), 32'd0);
    @(negedge clk);
    check("t1_fs_to_req_cycle2", 32'(burst_req), 32'd1);
    wait_until(1, 0, 3000, "t1_frame_done");
    check("t1_frame_done_count", 32'(n_fd), 32'd1);
    check("t1_busy_after_frame", 32'(busy), 32'd0);
    check("t1_all_reqs_seen", 32'(exp_q.size()), 32'd0);
    chk_done_lat = 1'b0;
    done_cyc     = -1;

    // Space threshold: 31 free stalls, 32 free issues.
    done_delay = 5;
    fifo_free  = 10'd31;
    push_frame(32'h0800_0000, 0, 24);
    nr0 = n_req;
    pulse_fs(32'h0800_0000);
    repeat (10) @(negedge clk);
    check("t2_no_req_at_31", 32'(n_req - nr0), 32'd0);
    check("t2_busy_waiting", 32'(busy), 32'd1);
    @(posedge clk); #1;
    fifo_free = 10'd32;
    @(negedge clk);
    check("t2_req_not_yet", 32'(burst_req), 32'd0);
    @(negedge clk);
    check("t2_req_at_32", 32'(burst_req), 32'd1);
    wait_until(1, 0, 1500, "t2_frame_done");
    check("t2_frame_done_count", 32'(n_fd), 32'd2);

    // Late frame start while burst 7 is in flight.
    done_delay = 10;
    fifo_free  = 10'd1023;
    push_frame(32'h1000_0000, 0, 7);
    push_frame(32'h2000_0000, 0, 24);
    pulse_fs(32'h1000_0000);
    wait_until(2, 7, 500, "t3_req7");
    wait_until(3, 0, 100, "t3_ack7");
    fd0 = n_fd;
    pulse_fs(32'h2000_0040);
    @(negedge clk);
    check("t3_late_frame", 32'(late_frame), 32'd1);
    wait_until(2, 0, 100, "t3_restart_req");
    check("t3_no_frame_done_on_restart", 32'(n_fd), 32'(fd0));
    wait_until(1, 0, 1500, "t3_frame_done");
    check("t3_frame_done_count", 32'(n_fd), 32'(fd0 + 1));

    // Ack held off 20 cycles while enable and frame_start toggle.
    pulse_clr();
    @(negedge clk);
    check("t4_late_cleared", 32'(late_frame), 32'd0);
    ack_delay = 20;
    exp_q.push_back('{addr: 32'h3000_0000, idx: 0});
    push_frame(32'h4000_0000, 0, 24);
    fd0 = n_fd;
    pulse_fs(32'h3000_0000);
    wait_until(2, 0, 100, "t4_first_req");
    ack_delay = 3;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      enable       = ~enable;
      fb_base_addr = 32'h4000_0000;
      frame_start  = (i % 5 == 1);
    end
    @(posedge clk); #1;
    enable      = 1'b1;
    frame_start = 1'b0;
    @(negedge clk);
    check("t4_req_still_held", 32'(burst_req), 32'd1);
    check("t4_late_frame", 32'(late_frame), 32'd1);
    wait_until(1, 0, 1500, "t4_frame_done");
    check("t4_frame_done_count", 32'(n_fd), 32'(fd0 + 1));
    check("t4_all_reqs_seen", 32'(exp_q.size()), 32'd0);

    // Read error on burst 3; next frame starts on the final done.
    pulse_clr();
    @(negedge clk);
    check("t5_late_clear", 32'(late_frame), 32'd0);
    check("t5_rd_error_clear", 32'(rd_error), 32'd0);
    err_idx = 3;
    push_frame(32'h5000_0000, 0, 24);
    pulse_fs(32'h5000_0000);
    wait_until(2, 4, 300, "t5_req4");
    check("t5_rd_error_set", 32'(rd_error), 32'd1);
    err_idx = -1;
    wait_until(4, 24, 1000, "t5_final_done");
    fb_base_addr = 32'h6000_0040;
    frame_start  = 1'b1;
    push_frame(32'h6000_0000, 0, 10);
    fd0 = n_fd;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk); #1;
    check("t5_frame_done_with_fs", 32'(n_fd), 32'(fd0 + 1));
    check("t5_no_late_on_final", 32'(late_frame), 32'd0);
    check("t5_new_frame_busy", 32'(busy), 32'd1);
    check("t5_rd_error_sticky", 32'(rd_error), 32'd1);

    // Enable drops during burst 10: drain, then stop.
    wait_until(2, 10, 300, "t6_req10");
    wait_until(3, 0, 100, "t6_ack10");
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    check("t6_drain_busy", 32'(busy), 32'd1);
    wait_until(0, 0, 100, "t6_idle");
    check("t6_idx_retained", 32'(burst_idx), 32'd10);
    nr0 = n_req;
    repeat (20) @(negedge clk);
    check("t6_no_req_after_drain", 32'(n_req - nr0), 32'd0);
    check("t6_all_reqs_seen", 32'(exp_q.size()), 32'd0);
    check("t6_no_frame_done", 32'(n_fd), 32'(fd0 + 1));
    pulse_clr();
    @(negedge clk);
    check("t5_err_clear", 32'(rd_error), 32'd0);
    pulse_fs(32'h7000_0000);
    repeat (3) @(negedge clk);
    check("t6_fs_ignored_disabled", 32'(busy), 32'd0);
    enable = 1'b1;
    push_frame(32'h7000_0000, 0, 24);
    pulse_fs(32'h7000_0000);
    wait_until(1, 0, 1500, "t6_restart_frame_done");
    check("t6_restart_all_reqs", 32'(exp_q.size()), 32'd0);
    check("t6_restart_frame_done", 32'(n_fd), 32'(fd0 + 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_fetch_scheduler.md
Name: vga_fetch_scheduler

Overview:
Sequences framebuffer fetches for the VGA scan-out path. It decides when the AXI full read master issues each burst, and at what address, using pixel-FIFO free space and frame-start events from the VGA timing side. It issues C_M_AXI_NUMBER_OF_BURST bursts per frame and keeps at most one burst outstanding. It sits in the M_AXI_ACLK domain between the VGA timing/FIFO logic and the burst read master.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, framebuffer address width
C_M_AXI_DATA_WIDTH, 32, AXI data width; beat bytes = C_M_AXI_DATA_WIDTH/8
C_M_AXI_BURST_LEN, 32, beats per burst (1..256, power of 2)
C_M_AXI_NUMBER_OF_BURST, 25, bursts per frame
C_BITS_WIDTH_FOR_NUMB_OF_BURST, 5, width of burst index; must hold NUMBER_OF_BURST-1
FIFO_CNT_WIDTH, 10, width of fifo_free

Ports:
M_AXI_ACLK  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  fetch enable; level
fb_base_addr  in  C_M_AXI_ADDR_WIDTH  frame base; sampled on accepted frame start
frame_start  in  1  one-cycle pulse, already synchronous to M_AXI_ACLK
fifo_free  in  FIFO_CNT_WIDTH  free words in pixel FIFO
burst_req  out  1  burst request to read master
burst_addr  out  C_M_AXI_ADDR_WIDTH  burst start address; valid while burst_req=1
burst_ack  in  1  master accepted request (ARVALID&ARREADY)
burst_done  in  1  last beat received (RVALID&RREADY&RLAST)
burst_err  in  1  non-OKAY RRESP seen in current burst; sampled with burst_done
err_clear  in  1  clears sticky flags
burst_idx  out  C_BITS_WIDTH_FOR_NUMB_OF_BURST  index of current/next burst
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after last burst of frame completes
late_frame  out  1  sticky: frame_start arrived before frame fetch finished
rd_error  out  1  sticky: burst_err seen with burst_done

Behaviour:
- Reset: state=IDLE. burst_req=0, burst_addr=0, burst_idx=0, busy=0, frame_done=0, late_frame=0, rd_error=0. Latched base=0, pend_start=0.
- States: IDLE, WAIT_SPACE, REQ, WAIT_DATA, DRAIN.
- IDLE: on frame_start & enable, latch base = fb_base_addr with the low log2(BURST_LEN*beat bytes) bits forced to 0. Set burst_idx=0 and go to WAIT_SPACE on the next cycle. frame_start with enable=0 is ignored.
- WAIT_SPACE: if enable=0, go to IDLE. If fifo_free >= C_M_AXI_BURST_LEN, go to REQ. The comparison uses fifo_free zero-extended.
- REQ: burst_req=1 and burst_addr = base + burst_idx*C_M_AXI_BURST_LEN*(C_M_AXI_DATA_WIDTH/8), modulo 2^ADDR_WIDTH. burst_addr is registered and stable for as long as burst_req=1. burst_req holds until burst_ack, regardless of enable, frame_start or fifo_free (AXI valid rule). On ack, burst_req drops on the next edge and the state goes to WAIT_DATA.
- burst_ack and burst_done can never assert in the same cycle as each other for one burst. burst_done arrives at least one cycle after ack.
- WAIT_DATA: on burst_done, set rd_error if burst_err=1.
  - If pend_start=1: go to the restart path.
  - Else if burst_idx == NUMBER_OF_BURST-1: pulse frame_done for 1 cycle, set burst_idx=0, go to IDLE.
  - Else: increment burst_idx. Go to WAIT_SPACE if enable=1, otherwise IDLE.
- frame_start while state is REQ or WAIT_DATA:
  - Set late_frame and set pend_start. Latch fb_base_addr in pend_base.
  - The current burst completes normally and its data is not discarded.
  - Restart path: base=pend_base, burst_idx=0, pend_start cleared, go to WAIT_SPACE. frame_done is not pulsed.
- frame_start while in WAIT_SPACE: set late_frame, latch the new base, set burst_idx=0, stay in WAIT_SPACE.
- frame_start in the same cycle as the final burst_done: late_frame is not set. The frame counts as complete (frame_done pulses) and the new frame starts: the state goes to WAIT_SPACE with the new base.
- DRAIN: entered from WAIT_DATA when enable drops mid-burst. Waits for burst_done, then goes to IDLE with burst_idx retained. A later frame_start resets burst_idx to 0.
- err_clear clears late_frame and rd_error next cycle. If err_clear and a set event occur in the same cycle, the set wins.
- Latency: frame_start to first burst_req is 2 cycles when fifo_free is sufficient. burst_done to next burst_req is 2 cycles.
- reset asserted mid-burst returns to the reset state immediately. The read master is reset by the same signal.

Decomposition:
- Shared package vga_axi_pkg: state encoding constants, BURST_BYTES = C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8, and ADDR_ALIGN_BITS = log2(BURST_BYTES).
- Single module with no sub-module. The address generator is a registered multiply-by-constant implemented as a shift.

Test Plan:
1. Reset, then frame_start with base 0x1000_0000 and fifo_free=1023, master acks in 3 cycles and done in 40. Expect 25 requests at 0x1000_0000 + n*0x80 for n=0..24, a single frame_done after the 25th done, then busy=0.
2. fifo_free=31 held (one below the burst length). Expect no burst_req. Raise fifo_free to 32: burst_req asserts 1 cycle after the WAIT_SPACE evaluation.
3. frame_start during WAIT_DATA of burst 7 with new base 0x2000_0040. Expect late_frame=1, burst 7 completes, then the next request is at 0x2000_0000 with idx=0 and no frame_done.
4. Hold burst_ack low for 20 cycles while toggling enable and frame_start. Expect burst_req and burst_addr stable throughout, and the deassert to follow the ack.
5. burst_err=1 with done on burst 3. Expect rd_error=1, fetching continues, and err_clear returns rd_error to 0.
6. Drop enable during WAIT_DATA of burst 10. Expect DRAIN, then IDLE after done with no further requests. A new frame_start then restarts at idx 0.
